jtag_tap_controller: RTL

Sequencer for the JTAG test-access port. It runs the IEEE 1149.1 16-state TAP state machine from TMS and produces the capture, shift and update strobes for the instruction register and for the data register that the instruction decoder currently selects (boundary-scan, ID, bypass or AHB). It also multiplexes the serial outputs of those registers onto a registered TDO. It sits between the chip pins and the instruction register, instruction decoder and data registers.

---
 rtl/jtag_types_pkg.sv | 43 ++++
 rtl/tap_fsm.sv | 50 +++++
 rtl/jtag_tap_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/jtag_types_pkg.sv
// jtag_types_pkg
// Shared JTAG types for the TAP controller slice.
//   tap_state_t   : 4-bit TAP state; the values are the IEEE 1149.1 Table 6-3
//                   encodings, so tap_state can be compared with other
//                   1149.1 tooling without any translation.
//   instruction_t : IR opcodes understood by the instruction decoder.
//   isShiftState  : true in SHIFT_DR or SHIFT_IR. These are the only states
//                   in which TDO carries scan data.
package jtag_types_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  // Opcodes. All-ones is BYPASS, as 1149.1 requires.
  typedef enum logic [3:0] {
    IR_EXTEST     = 4'h0,
    IR_SAMPLE     = 4'h1,
    IR_IDCODE     = 4'h2,
    IR_AHB_ACCESS = 4'h8,
    IR_BYPASS     = 4'hF
  } instruction_t;

  function automatic logic isShiftState(input tap_state_t s);
    return (s == SHIFT_DR) || (s == SHIFT_IR);
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// tap_fsm
// The 16-state IEEE 1149.1 TAP state register together with its next-state
// logic. It contains no output decode.
//   TCK       : test clock
//   TRST      : synchronous active-high reset to TEST_LOGIC_RESET. It
//               takes priority over TMS.
//   TMS       : test mode select, sampled on rising TCK
//   tap_state : current TAP state (registered)
module tap_fsm
  import jtag_types_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t tap_state
);

  tap_state_t r_state;

  // One transition per TCK. Each state has exactly two successors,
  // chosen by TMS.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      r_state <= TEST_LOGIC_RESET;
    end else begin
      unique case (r_state)
        TEST_LOGIC_RESET: r_state <= TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    r_state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
        SELECT_DR:        r_state <= TMS ? SELECT_IR        : CAPTURE_DR;
        CAPTURE_DR:       r_state <= TMS ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         r_state <= TMS ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         r_state <= TMS ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         r_state <= TMS ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         r_state <= TMS ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        r_state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
        SELECT_IR:        r_state <= TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       r_state <= TMS ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         r_state <= TMS ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         r_state <= TMS ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         r_state <= TMS ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         r_state <= TMS ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        r_state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
        default:          r_state <= TEST_LOGIC_RESET;
      endcase
    end
  end

  assign tap_state = r_state;

endmodule

// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller
// Top of the TAP sequencer. It wraps tap_fsm and adds the following logic:
//   - Moore strobe decode for the IR and for the data registers.
//   - A one-hot DR enable with priority bypass > id > ahb > bsr. When no
//     select is asserted, bypass is enabled.
//   - The TDO source mux and the registered TDO / tdo_en outputs.
// Ports:
//   TCK, TRST, TMS                  clock, synchronous reset, mode select
//   *_select                        DR selects from the instruction decoder
//   ir_tdo, bsr_tdo, id_tdo,
//   bypass_tdo, ahb_tdo             serial outputs of the IR and DRs
//   tap_state, tlr_reset            current state / Test-Logic-Reset flag
//   capture/shift/update_ir|dr      scan strobes
//   bsr_en, id_en, bypass_en, ahb_en one-hot DR enable
//   TDO, tdo_en                     registered serial out and driver enable
module jtag_tap_controller
  import jtag_types_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       bsr_select,
  input  logic       id_select,
  input  logic       bypass_select,
  input  logic       ahb_select,
  input  logic       ir_tdo,
  input  logic       bsr_tdo,
  input  logic       id_tdo,
  input  logic       bypass_tdo,
  input  logic       ahb_tdo,
  output tap_state_t tap_state,
  output logic       tlr_reset,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       bsr_en,
  output logic       id_en,
  output logic       bypass_en,
  output logic       ahb_en,
  output logic       TDO,
  output logic       tdo_en
);

  tap_state_t w_state;
  logic       w_drTdo;
  logic       w_enterTlr;
  logic       r_tdo;
  logic       r_tdoEn;

  tap_fsm u_tapFsm (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .tap_state (w_state)
  );

  assign tap_state = w_state;

  // The strobes are decoded from the state register alone. A TRST that
  // moves the state to TLR therefore drops every strobe in that same cycle.
  assign tlr_reset  = (w_state == TEST_LOGIC_RESET);
  assign capture_ir = (w_state == CAPTURE_IR);
  assign shift_ir   = (w_state == SHIFT_IR);
  assign update_ir  = (w_state == UPDATE_IR);
  assign capture_dr = (w_state == CAPTURE_DR);
  assign shift_dr   = (w_state == SHIFT_DR);
  assign update_dr  = (w_state == UPDATE_DR);

  // Priority encode of the DR selects. Bypass is enabled when nothing
  // else is selected, so exactly one enable is always high.
  always_comb begin
    bsr_en    = 1'b0;
    id_en     = 1'b0;
    bypass_en = 1'b0;
    ahb_en    = 1'b0;
    if (bypass_select || !(id_select || ahb_select || bsr_select)) begin
      bypass_en = 1'b1;
    end else if (id_select) begin
      id_en = 1'b1;
    end else if (ahb_select) begin
      ahb_en = 1'b1;
    end else begin
      bsr_en = 1'b1;
    end
  end

  always_comb begin
    w_drTdo = bsr_tdo;
    if (bypass_en) begin
      w_drTdo = bypass_tdo;
    end else if (id_en) begin
      w_drTdo = id_tdo;
    end else if (ahb_en) begin
      w_drTdo = ahb_tdo;
    end
  end

  // SELECT_IR with TMS=1 is the only path into TLR other than TRST.
  // Clearing TDO on that edge puts TDO at 0 as the state arrives in TLR.
  assign w_enterTlr = (w_state == SELECT_IR) && TMS;

  // TDO follows the shifted bit one cycle late and holds its value
  // outside the shift states. tdo_en marks the cycles in which TDO carries
  // scan data.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      r_tdo   <= 1'b0;
      r_tdoEn <= 1'b0;
    end else begin
      r_tdoEn <= isShiftState(w_state);
      if ((w_state == TEST_LOGIC_RESET) || w_enterTlr) begin
        r_tdo <= 1'b0;
      end else if (w_state == SHIFT_IR) begin
        r_tdo <= ir_tdo;
      end else if (w_state == SHIFT_DR) begin
        r_tdo <= w_drTdo;
      end
    end
  end

  assign TDO    = r_tdo;
  assign tdo_en = r_tdoEn;

endmodule
